// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential execute-stage ALU (alu_seq) and its
// combinational base-op evaluator (alu_base_comb).
//   - XLEN_DEFAULT : default operand/result width (legal widths: 32, 64)
//   - alu_op_e     : 5-bit operation select encoding
//   - ST_*         : FSM state encoding used by alu_seq
//   - is_base_op   : true for the single-cycle integer ops 0x00..0x09
// Optional feature macro used by the design: ALU_SEQ_DIV_EN (divide engine).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLT    = 5'h05,
    OP_SLL    = 5'h06,
    OP_SRL    = 5'h07,
    OP_SRA    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_MUL    = 5'h0A,
    OP_MULH   = 5'h0B,
    OP_MULHSU = 5'h0C,
    OP_MULHU  = 5'h0D,
    OP_DIV    = 5'h0E,
    OP_DIVU   = 5'h0F,
    OP_REM    = 5'h10,
    OP_REMU   = 5'h11
  } alu_op_e;

  // FSM state encoding, kept as plain constants so older tooling and
  // waveform scripts that expect fixed codes keep working.
  typedef logic [1:0] alu_state_t;
  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_MUL  = 2'd1;
  localparam alu_state_t ST_DIV  = 2'd2;
  localparam alu_state_t ST_DONE = 2'd3;

  function automatic logic is_base_op(input logic [4:0] op);
    return (op <= 5'h09);
  endfunction

endpackage

// File: rtl/alu_base_comb.sv
// -----------------------------------------------------------------------------
// alu_base_comb
// Purely combinational evaluator for the ten base integer ops (0x00..0x09).
// Any other op code yields zero. Shifts use the low $clog2(XLEN) bits of b.
// Ports:
//   a, b : XLEN-bit operands
//   op   : 5-bit operation select (alu_pkg::alu_op_e encoding)
//   y    : XLEN-bit result
// -----------------------------------------------------------------------------
module alu_base_comb
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic [XLEN-1:0] y
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt_s;
  logic               lt_s;
  logic               ltu_s;

  assign shamt_s = b[SHAMT_W-1:0];
  assign lt_s    = ($signed(a) < $signed(b));
  assign ltu_s   = (a < b);

  // Base-op result mux; unlisted codes fall through to zero.
  always_comb begin
    y = {XLEN{1'b0}};
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLL:  y = a << shamt_s;
      OP_SRL:  y = a >> shamt_s;
      OP_SRA:  y = $signed(a) >>> shamt_s;
      OP_SLTU: y = {{(XLEN-1){1'b0}}, ltu_s};
      default: y = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Execute-stage ALU behind a valid/ready handshake. Base ops and illegal codes
// complete in one cycle; MUL/MULH/MULHSU/MULHU run an iterative radix-2
// shift-add engine (XLEN+1 cycles). With ALU_SEQ_DIV_EN defined, DIV/DIVU/
// REM/REMU run a restoring divider (XLEN+1 cycles, divide-by-zero and signed
// overflow finish in one cycle); without it those codes behave as illegal.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : op acceptance (in_ready high only in IDLE)
//   a, b, alu_ctrl       : operands and 5-bit op select
//   out_valid / out_ready: result handshake; result/zero hold until taken
//   result, zero         : registered result and its ==0 flag
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(XLEN - 1);

  // ---------------------------------------------------------------- state
  alu_state_t          state_r;
  logic [4:0]          op_r;
  logic [XLEN-1:0]     result_r;
  logic                zero_r;
  logic [SHAMT_W-1:0]  cnt_r;
  logic [XLEN-1:0]     mcand_r;
  logic [2*XLEN-1:0]   prod_r;
  logic                neg_r;     // sign of product / quotient

  // ------------------------------------------------------ accept decode
  logic                is_mul_s;
  logic                a_signed_s;
  logic                b_signed_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic [XLEN-1:0]     base_y_s;
  logic [XLEN-1:0]     fast_res_s;

  // ------------------------------------------------------ multiplier
  logic [XLEN:0]       mul_sum_s;
  logic [2*XLEN-1:0]   prod_nxt_s;
  logic [2*XLEN-1:0]   prod_fix_s;
  logic [XLEN-1:0]     mul_res_s;

`ifdef ALU_SEQ_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0]     dvsr_r;
  logic [XLEN-1:0]     quo_r;
  logic [XLEN-1:0]     rem_r;
  logic                rem_neg_r;

  logic                is_div_s;
  logic                is_rem_s;
  logic                b_zero_s;
  logic                ovf_s;
  logic                div_special_s;
  logic [XLEN:0]       rem_sh_s;
  logic [XLEN:0]       rem_diff_s;
  logic                rem_ge_s;
  logic [XLEN-1:0]     rem_nxt_s;
  logic [XLEN-1:0]     quo_nxt_s;
  logic [XLEN-1:0]     div_q_s;
  logic [XLEN-1:0]     div_r_s;
  logic [XLEN-1:0]     div_res_s;
`endif

  alu_base_comb #(.XLEN(XLEN)) u_base (
    .a  (a),
    .b  (b),
    .op (alu_ctrl),
    .y  (base_y_s)
  );

  // Classify the incoming op and decide operand signedness.
  always_comb begin
    is_mul_s   = 1'b0;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    is_div_s   = 1'b0;
`endif
    case (alu_ctrl)
      OP_MUL, OP_MULH: begin
        is_mul_s   = 1'b1;
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        is_mul_s   = 1'b1;
        a_signed_s = 1'b1;
      end
      OP_MULHU: is_mul_s = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV, OP_REM: begin
        is_div_s   = 1'b1;
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_DIVU, OP_REMU: is_div_s = 1'b1;
`endif
      default: is_mul_s = 1'b0;
    endcase
  end

  // Engines work on magnitudes; the most-negative value maps to 2^(XLEN-1),
  // which still fits unsigned in XLEN bits.
  assign a_neg_s = a_signed_s & a[XLEN-1];
  assign b_neg_s = b_signed_s & b[XLEN-1];
  assign mag_a_s = a_neg_s ? -a : a;
  assign mag_b_s = b_neg_s ? -b : b;

`ifdef ALU_SEQ_DIV_EN
  assign is_rem_s      = (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
  assign b_zero_s      = (b == {XLEN{1'b0}});
  assign ovf_s         = a_signed_s && (a == MOST_NEG) && (b == {XLEN{1'b1}});
  assign div_special_s = is_div_s && (b_zero_s || ovf_s);

  // One-cycle result: base op, illegal code, or a divide corner case.
  always_comb begin
    fast_res_s = base_y_s;
    if (is_div_s && b_zero_s) begin
      fast_res_s = is_rem_s ? a : {XLEN{1'b1}};
    end else if (is_div_s && ovf_s) begin
      fast_res_s = is_rem_s ? {XLEN{1'b0}} : a;
    end else begin
      fast_res_s = base_y_s;
    end
  end
`else
  // Base ops and illegal codes (including the divide codes) take the base path.
  assign fast_res_s = base_y_s;
`endif

  // Shift-add step: low half of prod_r holds the remaining multiplier bits,
  // high half accumulates; the carry goes into the top bit as we shift right.
  assign mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]}
                    + (prod_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
  assign prod_nxt_s = {mul_sum_s, prod_r[XLEN-1:1]};
  // Final step is folded into the last iteration so latency stays XLEN+1.
  assign prod_fix_s = neg_r ? -prod_nxt_s : prod_nxt_s;
  assign mul_res_s  = (op_r == OP_MUL) ? prod_fix_s[XLEN-1:0]
                                       : prod_fix_s[2*XLEN-1:XLEN];

`ifdef ALU_SEQ_DIV_EN
  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract. Bit XLEN of the difference is the borrow, since the true
  // difference lies in (-divisor, divisor).
  assign rem_sh_s   = {rem_r, quo_r[XLEN-1]};
  assign rem_diff_s = rem_sh_s - {1'b0, dvsr_r};
  assign rem_ge_s   = ~rem_diff_s[XLEN];
  assign rem_nxt_s  = rem_ge_s ? rem_diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_nxt_s  = {quo_r[XLEN-2:0], rem_ge_s};
  assign div_q_s    = neg_r ? -quo_nxt_s : quo_nxt_s;
  assign div_r_s    = rem_neg_r ? -rem_nxt_s : rem_nxt_s;
  assign div_res_s  = ((op_r == OP_REM) || (op_r == OP_REMU)) ? div_r_s : div_q_s;
`endif

  // Control FSM plus operand/iteration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 5'h00;
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b1;
      cnt_r     <= {SHAMT_W{1'b0}};
      mcand_r   <= {XLEN{1'b0}};
      prod_r    <= {(2*XLEN){1'b0}};
      neg_r     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      dvsr_r    <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      rem_neg_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r  <= alu_ctrl;
            cnt_r <= {SHAMT_W{1'b0}};
            if (is_mul_s) begin
              mcand_r <= mag_a_s;
              prod_r  <= {{XLEN{1'b0}}, mag_b_s};
              neg_r   <= a_neg_s ^ b_neg_s;
              state_r <= ST_MUL;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (is_div_s && !div_special_s) begin
              dvsr_r    <= mag_b_s;
              quo_r     <= mag_a_s;
              rem_r     <= {XLEN{1'b0}};
              neg_r     <= a_neg_s ^ b_neg_s;
              rem_neg_r <= a_neg_s;
              state_r   <= ST_DIV;
            end
`endif
            else begin
              result_r <= fast_res_s;
              zero_r   <= (fast_res_s == {XLEN{1'b0}});
              state_r  <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          prod_r <= prod_nxt_s;
          cnt_r  <= cnt_r + 1'b1;
          if (cnt_r == LAST_ITER) begin
            result_r <= mul_res_s;
            zero_r   <= (mul_res_s == {XLEN{1'b0}});
            state_r  <= ST_DONE;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        ST_DIV: begin
          quo_r <= quo_nxt_s;
          rem_r <= rem_nxt_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_ITER) begin
            result_r <= div_res_s;
            zero_r   <= (div_res_s == {XLEN{1'b0}});
            state_r  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign result    = result_r;
  assign zero      = zero_r;

endmodule
